lcd_pattern_gen: RTL and testbench

- Parametrised successor to the fixed 800x480 LCD timing/pattern block. Generates DE/HSYNC/VSYNC for any panel timing, with configurable sync polarity.
- Drives RGB565 from one of four runtime-selectable test patterns; mode changes are tear-free.
- Sits between the PLL pixel clock and the LCD pins; also exports frame status for LED/diagnostic logic.

---
 rtl/lcd_pattern_gen_if.sv | 23 ++
 rtl/lcd_pattern_gen.sv | 152 +++++++++++++++
 tb/tb_lcd_pattern_gen.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pattern_gen_if.sv
// Pattern-select inputs and LCD pin/status outputs of lcd_pattern_gen.
// The master side is the generator and the slave side is the panel or bench.
interface lcd_pattern_gen_if;
    logic [1:0]  MODE;
    logic [15:0] SOLID_RGB;
    logic        LCD_DE;
    logic        LCD_HSYNC;
    logic        LCD_VSYNC;
    logic [4:0]  LCD_R;
    logic [5:0]  LCD_G;
    logic [4:0]  LCD_B;
    logic        FRAME_START;
    logic [7:0]  FRAME_CNT;

    modport master (
        input  MODE, SOLID_RGB,
        output LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B, FRAME_START, FRAME_CNT
    );
    modport slave (
        output MODE, SOLID_RGB,
        input  LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B, FRAME_START, FRAME_CNT
    );
endinterface

// File: rtl/lcd_pattern_gen.sv
// Parametrised LCD timing generator with four test patterns (RGB565).
// Every output is registered one cycle after the counter state it reflects.
module lcd_pattern_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 210,
    parameter int H_SYNC     = 20,
    parameter int H_BP       = 26,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 22,
    parameter int V_SYNC     = 10,
    parameter int V_BP       = 13,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int GRID_SHIFT = 5
) (
    input  logic               CLK,
    input  logic               nRST,
    lcd_pattern_gen_if.master  lcd
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BW      = H_ACTIVE / 8;
    localparam int BPW     = $clog2(BW + 1);

    localparam logic [HW-1:0]  H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0]  H_EDGE   = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]  HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]  V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]  V_EDGE   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]  VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BPW-1:0] BAR_LAST = BPW'(BW - 1);
    localparam logic           HS_ACT   = 1'(HS_POL);
    localparam logic           VS_ACT   = 1'(VS_POL);

    logic [HW-1:0]  h_cnt_q, h_cnt_d;
    logic [VW-1:0]  v_cnt_q, v_cnt_d;
    logic [2:0]     bar_idx_q, bar_idx_d;
    logic [BPW-1:0] bar_px_q, bar_px_d;
    logic [1:0]     mode_q, mode_d;
    logic [15:0]    solid_q, solid_d;
    logic           de_q, de_d;
    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic [15:0]    rgb_q, rgb_d;
    logic           fs_q, fs_d;
    logic [7:0]     fcnt_q, fcnt_d;

    logic           active;
    logic [7:0]     x8, y8;
    logic [15:0]    bar_rgb, pix;

    always_comb begin
        h_cnt_d   = h_cnt_q + 1'b1;
        v_cnt_d   = v_cnt_q;
        bar_idx_d = bar_idx_q;
        bar_px_d  = bar_px_q + 1'b1;
        mode_d    = mode_q;
        solid_d   = solid_q;

        // Bar counter tracks h_cnt; saturating at 7 lets the last bar absorb the remainder.
        if (h_cnt_q == H_LAST) begin
            h_cnt_d   = '0;
            bar_idx_d = '0;
            bar_px_d  = '0;
            v_cnt_d   = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end else if (bar_px_q == BAR_LAST) begin
            bar_px_d = '0;
            if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 1'b1;
        end

        // Pattern inputs only change on the last clock of a frame, so a frame never tears.
        if (h_cnt_q == H_LAST && v_cnt_q == V_LAST) begin
            mode_d  = lcd.MODE;
            solid_d = lcd.SOLID_RGB;
        end

        active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        x8     = 8'(h_cnt_q);
        y8     = 8'(v_cnt_q);

        case (bar_idx_q)
            3'd0:    bar_rgb = 16'hFFFF;
            3'd1:    bar_rgb = 16'hFFE0;
            3'd2:    bar_rgb = 16'h07FF;
            3'd3:    bar_rgb = 16'h07E0;
            3'd4:    bar_rgb = 16'hF81F;
            3'd5:    bar_rgb = 16'hF800;
            3'd6:    bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase

        case (mode_q)
            2'd0:    pix = bar_rgb;
            2'd1:    pix = (x8[GRID_SHIFT-1:0] == '0 || y8[GRID_SHIFT-1:0] == '0 ||
                            h_cnt_q == H_EDGE || v_cnt_q == V_EDGE) ? 16'hFFFF : 16'h0000;
            2'd2:    pix = {x8[7:3], y8[7:2], 5'((x8 + y8) >> 3)};
            default: pix = solid_q;
        endcase

        rgb_d  = active ? pix : 16'h0000;
        de_d   = active;
        hs_d   = (h_cnt_q >= HS_BEG && h_cnt_q < HS_END) ? HS_ACT : ~HS_ACT;
        vs_d   = (v_cnt_q >= VS_BEG && v_cnt_q < VS_END) ? VS_ACT : ~VS_ACT;
        fs_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
        fcnt_d = fs_d ? fcnt_q + 1'b1 : fcnt_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            bar_idx_q <= '0;
            bar_px_q  <= '0;
            mode_q    <= '0;
            solid_q   <= '0;
            de_q      <= 1'b0;
            hs_q      <= ~HS_ACT;
            vs_q      <= ~VS_ACT;
            rgb_q     <= '0;
            fs_q      <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_idx_q <= bar_idx_d;
            bar_px_q  <= bar_px_d;
            mode_q    <= mode_d;
            solid_q   <= solid_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            rgb_q     <= rgb_d;
            fs_q      <= fs_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign lcd.LCD_DE      = de_q;
    assign lcd.LCD_HSYNC   = hs_q;
    assign lcd.LCD_VSYNC   = vs_q;
    assign lcd.LCD_R       = rgb_q[15:11];
    assign lcd.LCD_G       = rgb_q[10:5];
    assign lcd.LCD_B       = rgb_q[4:0];
    assign lcd.FRAME_START = fs_q;
    assign lcd.FRAME_CNT   = fcnt_q;
endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Bench for lcd_pattern_gen: a small-timing instance checked pixel by pixel against a
// scoreboard, plus a tiny inverted-polarity instance for sync polarity and frame-count wrap.
module tb_lcd_pattern_gen;
    localparam int HA = 68, HFP = 4, HSW = 3, HBP = 5, HT = HA + HFP + HSW + HBP;
    localparam int VA = 40, VFP = 2, VSW = 2, VBP = 3, VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int BW = HA / 8;
    localparam int GS = 3;
    localparam int TFRAME = 11 * 5;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [15:0] rgb;
        logic        fs;
        logic [7:0]  fc;
    } px_t;

    localparam px_t RST_PX = '{de: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 16'h0, fs: 1'b0, fc: 8'h0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    always #5 clk = ~clk;

    lcd_pattern_gen_if bus();
    lcd_pattern_gen_if bus2();

    lcd_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(0), .VS_POL(0), .GRID_SHIFT(GS)
    ) dut (.CLK(clk), .nRST(rst_n), .lcd(bus));

    lcd_pattern_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .GRID_SHIFT(3)
    ) dut2 (.CLK(clk), .nRST(rst2_n), .lcd(bus2));

    px_t        sb[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         mh, mv, out_x, out_y;
    logic [1:0] mmode, out_md;
    logic [15:0] msolid;
    logic [7:0] mfcnt;

    function automatic logic [15:0] bar_col(int i);
        case (i)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic px_t model_px(int x, int y, logic [1:0] md, logic [15:0] sc, logic [7:0] fc);
        px_t e;
        int  idx;
        e.de  = (x < HA) && (y < VA);
        e.hs  = (x >= HA + HFP && x < HA + HFP + HSW) ? 1'b0 : 1'b1;
        e.vs  = (y >= VA + VFP && y < VA + VFP + VSW) ? 1'b0 : 1'b1;
        e.rgb = 16'h0;
        if (e.de) begin
            case (md)
                2'd0: begin
                    idx = x / BW;
                    if (idx > 7) idx = 7;
                    e.rgb = bar_col(idx);
                end
                2'd1: e.rgb = ((x % 8) == 0 || (y % 8) == 0 || x == HA - 1 || y == VA - 1) ? 16'hFFFF : 16'h0;
                2'd2: e.rgb = {5'((x >> 3) & 31), 6'((y >> 2) & 63), 5'(((x + y) >> 3) & 31)};
                default: e.rgb = sc;
            endcase
        end
        e.fs = (x == 0) && (y == 0);
        e.fc = fc;
        return e;
    endfunction

    function automatic px_t sample();
        px_t s;
        s.de  = bus.LCD_DE;
        s.hs  = bus.LCD_HSYNC;
        s.vs  = bus.LCD_VSYNC;
        s.rgb = {bus.LCD_R, bus.LCD_G, bus.LCD_B};
        s.fs  = bus.FRAME_START;
        s.fc  = bus.FRAME_CNT;
        return s;
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0; mmode = 2'd0; msolid = 16'h0; mfcnt = 8'h0;
        sb.delete();
    endtask

    // Advance the reference model one pixel clock and queue what the DUT must show.
    task automatic step_main();
        @(posedge clk);
        if (mh == 0 && mv == 0) mfcnt = mfcnt + 8'd1;
        sb.push_back(model_px(mh, mv, mmode, msolid, mfcnt));
        out_x = mh; out_y = mv; out_md = mmode;
        if (mh == HT - 1 && mv == VT - 1) begin
            mmode  = bus.MODE;
            msolid = bus.SOLID_RGB;
        end
        if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        px_t got;
        rst_n = 1'b0; rst2_n = 1'b0;
        bus.MODE = 2'd0; bus.SOLID_RGB = 16'h0;
        bus2.MODE = 2'd0; bus2.SOLID_RGB = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        got = sample();
        n_chk++;
        if (got !== RST_PX) begin
            n_fail++;
            $display("FAIL reset_main got=%h exp=%h", got, RST_PX);
        end
        n_chk++;
        if ({bus2.LCD_DE, bus2.LCD_HSYNC, bus2.LCD_VSYNC, bus2.FRAME_START, bus2.FRAME_CNT} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_tiny got de/hs/vs/fs/fc=%b%b%b%b/%h exp 0000/00",
                     bus2.LCD_DE, bus2.LCD_HSYNC, bus2.LCD_VSYNC, bus2.FRAME_START, bus2.FRAME_CNT);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_bars_timing();
        px_t got, exp;
        logic [15:0] want;
        int de_cnt = 0, de_line0 = 0, hs_first = -1, hs_low0 = 0, fs_cnt = 0, fs_last = -1;
        for (int k = 0; k <= FRAME; k++) begin
            step_main();
            got = sample();
            exp = sb.pop_front();
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL bars_sb (%0d,%0d) got=%h exp=%h", out_x, out_y, got, exp);
            end
            if (k < FRAME && got.de) de_cnt++;
            if (out_y == 0 && k < HT) begin
                if (got.de) de_line0++;
                if (!got.hs) begin
                    hs_low0++;
                    if (hs_first < 0) hs_first = k;
                end
            end
            if (got.fs) begin fs_cnt++; fs_last = k; end
            if (out_y == 0 && (out_x == 0 || out_x == 7 || out_x == 8 || out_x == 56 || out_x == 67)) begin
                want = (out_x < 8) ? 16'hFFFF : (out_x == 8) ? 16'hFFE0 : 16'h0000;
                n_chk++;
                if (got.rgb !== want) begin
                    n_fail++;
                    $display("FAIL bars_pixel x=%0d got=%h exp=%h", out_x, got.rgb, want);
                end
            end
        end
        n_chk++;
        if (de_cnt != HA * VA) begin n_fail++; $display("FAIL de_frame_count got=%0d exp=%0d", de_cnt, HA * VA); end
        n_chk++;
        if (de_line0 != HA) begin n_fail++; $display("FAIL de_line_count got=%0d exp=%0d", de_line0, HA); end
        n_chk++;
        if (hs_first != HA + HFP || hs_low0 != HSW) begin
            n_fail++;
            $display("FAIL hsync_pos got start=%0d width=%0d exp start=%0d width=%0d", hs_first, hs_low0, HA + HFP, HSW);
        end
        n_chk++;
        if (fs_cnt != 2 || fs_last != FRAME) begin
            n_fail++;
            $display("FAIL frame_period got pulses=%0d last=%0d exp pulses=2 last=%0d", fs_cnt, fs_last, FRAME);
        end
    endtask

    task automatic test_grid();
        px_t got, exp;
        logic [15:0] want;
        int hits = 0;
        bus.MODE = 2'd1;
        for (int k = 0; k < 2 * FRAME - 1; k++) begin
            step_main();
            got = sample();
            exp = sb.pop_front();
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL grid_sb (%0d,%0d) got=%h exp=%h", out_x, out_y, got, exp);
            end
            if (out_md == 2'd1 && ((out_x == 8 && out_y == 5) || (out_x == 9 && out_y == 5) ||
                                   (out_x == 67 && out_y == 20) || (out_x == 10 && out_y == 40))) begin
                hits++;
                want = (out_x == 9 || out_y == 40) ? 16'h0000 : 16'hFFFF;
                n_chk++;
                if (got.rgb !== want) begin
                    n_fail++;
                    $display("FAIL grid_pixel (%0d,%0d) got=%h exp=%h", out_x, out_y, got.rgb, want);
                end
            end
        end
        n_chk++;
        if (hits != 4) begin n_fail++; $display("FAIL grid_coverage got=%0d exp=4", hits); end
    endtask

    task automatic test_gradient();
        px_t got, exp;
        logic [15:0] want;
        int hits = 0;
        bus.MODE = 2'd2;
        for (int k = 0; k < 2 * FRAME; k++) begin
            step_main();
            got = sample();
            exp = sb.pop_front();
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL grad_sb (%0d,%0d) got=%h exp=%h", out_x, out_y, got, exp);
            end
            if (out_md == 2'd2 && ((out_x == 67 && out_y == 39) || (out_x == 20 && out_y == 12))) begin
                hits++;
                want = (out_x == 67) ? {5'd8, 6'd9, 5'd13} : {5'd2, 6'd3, 5'd4};
                n_chk++;
                if (got.rgb !== want) begin
                    n_fail++;
                    $display("FAIL grad_pixel (%0d,%0d) got=%h exp=%h", out_x, out_y, got.rgb, want);
                end
            end
        end
        n_chk++;
        if (hits != 2) begin n_fail++; $display("FAIL grad_coverage got=%0d exp=2", hits); end
    endtask

    task automatic test_tear_free();
        px_t got, exp;
        for (int k = 0; k <= FRAME; k++) begin
            step_main();
            got = sample();
            exp = sb.pop_front();
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL tear_sb (%0d,%0d) got=%h exp=%h", out_x, out_y, got, exp);
            end
            if (out_x == 0 && out_y == 10 && k < FRAME) begin
                bus.MODE = 2'd3;
                bus.SOLID_RGB = 16'hF800;
            end
            if (k < FRAME && out_x == 20 && out_y == 12) begin
                n_chk++;
                if (got.rgb !== {5'd2, 6'd3, 5'd4}) begin
                    n_fail++;
                    $display("FAIL tear_hold got=%h exp=%h", got.rgb, {5'd2, 6'd3, 5'd4});
                end
            end
            if (k == FRAME) begin
                n_chk++;
                if (got.rgb !== 16'hF800 || got.fs !== 1'b1) begin
                    n_fail++;
                    $display("FAIL tear_switch got rgb=%h fs=%b exp rgb=f800 fs=1", got.rgb, got.fs);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        px_t got, exp;
        for (int k = 0; k < FRAME && !(out_x == 40 && out_y == 20); k++) begin
            step_main();
            got = sample();
            exp = sb.pop_front();
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL areset_pre_sb (%0d,%0d) got=%h exp=%h", out_x, out_y, got, exp);
            end
        end
        n_chk++;
        if (!(out_x == 40 && out_y == 20)) begin
            n_fail++;
            $display("FAIL areset_reach got (%0d,%0d) exp (40,20)", out_x, out_y);
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = sample();
        n_chk++;
        if (got !== RST_PX) begin n_fail++; $display("FAIL areset_immediate got=%h exp=%h", got, RST_PX); end
        @(posedge clk);
        #1;
        got = sample();
        n_chk++;
        if (got !== RST_PX) begin n_fail++; $display("FAIL areset_hold got=%h exp=%h", got, RST_PX); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= FRAME; k++) begin
            step_main();
            got = sample();
            exp = sb.pop_front();
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL areset_post_sb (%0d,%0d) got=%h exp=%h", out_x, out_y, got, exp);
            end
            if (k == 0) begin
                n_chk++;
                if (got.fs !== 1'b1 || got.fc !== 8'd1 || got.rgb !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL areset_first got fs=%b fc=%0d rgb=%h exp fs=1 fc=1 rgb=ffff", got.fs, got.fc, got.rgb);
                end
            end
        end
    endtask

    task automatic test_polarity();
        int hs_cnt = 0, hs_first = -1, vs_cnt = 0, vs_first = -1, vs_last = -1, de_cnt = 0;
        rst2_n = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if (bus2.LCD_HSYNC !== 1'b0 || bus2.LCD_VSYNC !== 1'b0) begin
            n_fail++;
            $display("FAIL pol_idle got hs=%b vs=%b exp hs=0 vs=0", bus2.LCD_HSYNC, bus2.LCD_VSYNC);
        end
        @(negedge clk);
        rst2_n = 1'b1;
        for (int k = 0; k < TFRAME; k++) begin
            @(posedge clk);
            #1;
            if (bus2.LCD_DE) de_cnt++;
            if (bus2.LCD_HSYNC) begin hs_cnt++; if (hs_first < 0) hs_first = k; end
            if (bus2.LCD_VSYNC) begin vs_cnt++; if (vs_first < 0) vs_first = k; vs_last = k; end
        end
        n_chk++;
        if (hs_cnt != 5 || hs_first != 9) begin
            n_fail++;
            $display("FAIL pol_hsync got count=%0d first=%0d exp count=5 first=9", hs_cnt, hs_first);
        end
        n_chk++;
        if (vs_cnt != 11 || vs_first != 33 || vs_last != 43) begin
            n_fail++;
            $display("FAIL pol_vsync got count=%0d span=%0d..%0d exp count=11 span=33..43", vs_cnt, vs_first, vs_last);
        end
        n_chk++;
        if (de_cnt != 16) begin n_fail++; $display("FAIL pol_de got=%0d exp=16", de_cnt); end
    endtask

    task automatic test_frame_wrap();
        int pulses = 0;
        logic [7:0] fc_256 = 8'hxx;
        rst2_n = 1'b0;
        #1;
        n_chk++;
        if (bus2.FRAME_CNT !== 8'd0) begin n_fail++; $display("FAIL wrap_reset got=%0d exp=0", bus2.FRAME_CNT); end
        @(negedge clk);
        rst2_n = 1'b1;
        for (int k = 0; k < 257 * TFRAME + 20 && pulses < 257; k++) begin
            @(posedge clk);
            #1;
            if (bus2.FRAME_START) begin
                pulses++;
                if (pulses == 256) fc_256 = bus2.FRAME_CNT;
                n_chk++;
                if (bus2.FRAME_CNT !== 8'(pulses)) begin
                    n_fail++;
                    $display("FAIL wrap_count pulse=%0d got=%0d exp=%0d", pulses, bus2.FRAME_CNT, 8'(pulses));
                end
            end
        end
        n_chk++;
        if (pulses != 257 || fc_256 !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_256 got pulses=%0d cnt=%h exp pulses=257 cnt=00", pulses, fc_256);
        end
    endtask

    initial begin
        test_reset();
        test_bars_timing();
        test_grid();
        test_gradient();
        test_tear_free();
        test_async_reset();
        test_polarity();
        test_frame_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
